irq_status: RTL and testbench
=============================

IRQ_STATUS -- requirements
Module: irq_status

Interface
REQ-001 clk  input  1  single system clock; all logic on rising edge.
REQ-002 rst  input  1  synchronous reset, active-high.
REQ-003 cs  input  1  interrupt-status chip select: A13..A10 = 1011.
REQ-004 strobe  input  1  one-clk access strobe; an access occurs only when cs & strobe.
REQ-005 rnw  input  1  1 = read, 0 = write.
REQ-006 a  input  2  register select, host address bits 3:2.
REQ-007 wdata  input  8  write data.
REQ-008 rdata  output  8  registered read data.
REQ-009 irq_in  input  4  asynchronous requests: bit0 Econet, bit1 Ethernet, bit2 IDE, bit3 UART.
REQ-010 irq_out  output  1  registered podule IRQ, active-high.
REQ-011 fiq_out  output  1  registered podule FIQ, active-high.

Function
REQ-012 Each irq_in bit SHALL pass through a 2-flop synchroniser; sync(n) denotes the second-flop output.
REQ-013 Register map, a = 00 STATUS: read returns {4'b0, pend[3:0]}; a write of 1 to a bit clears an edge-mode pend bit.
REQ-014 Register map, a = 01 MASK: read/write, bits 3:0; bits 7:4 read as 0.
REQ-015 Register map, a = 10 MODE: read/write; bits 3:0 select edge (1) or level (0) per source; bits 7:4 route the source to FIQ (1) or IRQ (0).
REQ-016 Register map, a = 11 VECTOR: read-only; returns {valid, 4'b0, id[2:0]}; writes are ignored.
REQ-017 VECTOR id SHALL be the lowest-numbered set bit of pend & MASK (bit0 highest priority); valid = 0 and id = 0 when none is set.
REQ-018 In level mode, pend(n) SHALL equal sync(n) every clk; STATUS write-1 has no effect.
REQ-019 In edge mode, pend(n) SHALL set on the clk after sync(n) goes 0->1 and hold until a STATUS write-1 clears it.
REQ-020 If a set and a clear of pend(n) occur in the same clk, the set SHALL win.
REQ-021 Changing MODE(n) from edge to level SHALL make pend(n) follow sync(n) from the next clk; changing level to edge SHALL retain the current pend(n) value.
REQ-022 Latency from an irq_in(n) rising edge to pend(n) SHALL be 3 clk (2 synchroniser + 1 edge/latch).
REQ-023 irq_out SHALL register |(pend & MASK & ~ROUTE), one clk after pend changes.
REQ-024 fiq_out SHALL register |(pend & MASK & ROUTE), one clk after pend changes.
REQ-025 Reads: rdata SHALL be valid on the clk after the strobe and hold until the next read.
REQ-026 Register writes take effect on the clk edge at which strobe is sampled.
REQ-027 A read SHALL return register values from before any update made in the same clk.
REQ-028 Strobes with cs = 0 SHALL cause no state change.

Reset
REQ-029 Reset SHALL clear the synchronisers, pend, MASK, MODE, rdata, irq_out and fiq_out to 0.
REQ-030 Reset SHALL clear any edge-detect history, so that a request already high when rst falls is seen as an edge.
REQ-031 Reset asserted mid-access SHALL abort the access with no register update.

Structure
REQ-032 A shared package SHALL hold the register offsets (STATUS/MASK/MODE/VECTOR), the source bit indices and the source count (4).
REQ-033 One sub-module, irq_sync_edge, SHALL contain the 2-flop synchroniser plus rising-edge detect per source, instantiated 4 times.
REQ-034 The priority encoder SHALL be combinational in the top level.

Verification
REQ-035 Reset, then read all four registers -> every rdata = 8'h00; irq_out = fiq_out = 0.
REQ-036 MODE = 8'h0F, MASK = 8'h04, pulse irq_in[2] for 1 clk -> STATUS = 8'h04 on the 3rd clk; irq_out = 1 on the 4th; VECTOR = 8'h82; write STATUS 8'h04 -> irq_out = 0 one clk after the clear.
REQ-037 MODE = 8'h1F, MASK = 8'h0F, raise irq_in[0] and irq_in[3] -> fiq_out = 1 and irq_out = 1; VECTOR = 8'h80.
REQ-038 Edge mode, issue a STATUS write-1 of bit 1 in the same clk as the bit-1 set -> pend[1] remains 1.
REQ-039 Level mode (MODE = 8'h00), MASK = 8'h08, hold irq_in[3] high -> STATUS = 8'h08 and writes do not clear it; drop irq_in[3] -> irq_out = 0 four clk later.
REQ-040 Assert rst with pend = 8'h0F and irq_in[1] held high, then release -> pend[1] re-sets when MODE(1) = edge; a strobe with cs = 0 alters nothing.

Source files
------------

// File: rtl/irq_status_pkg.sv
// Shared definitions for the podule interrupt-status block: register map,
// source bit indices and the VECTOR register layout.
package irq_status_pkg;

   localparam int unsigned NUM_SRC = 4;
   localparam int unsigned ADDR_W  = 2;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned ID_W    = 3;

   localparam logic [ADDR_W-1:0] REG_STATUS = 2'b00;
   localparam logic [ADDR_W-1:0] REG_MASK   = 2'b01;
   localparam logic [ADDR_W-1:0] REG_MODE   = 2'b10;
   localparam logic [ADDR_W-1:0] REG_VECTOR = 2'b11;

   localparam int unsigned SRC_ECONET   = 0;
   localparam int unsigned SRC_ETHERNET = 1;
   localparam int unsigned SRC_IDE      = 2;
   localparam int unsigned SRC_UART     = 3;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } vector_t;

   // VECTOR read layout: {valid, 4'b0, id}
   function automatic logic [DATA_W-1:0] pack_vector(input vector_t v);
      return {v.valid, (DATA_W-1-ID_W)'(0), v.id};
   endfunction

endpackage

// File: rtl/irq_status_sync_edge.sv
// Two-flop synchroniser for one asynchronous request plus rising-edge detect
// on the synchronised level.
module irq_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic req,
   output logic sync,
   output logic rise_c
);

   logic meta;
   logic sync_d;

   // Clearing sync_d on reset makes a request already high at release look like an edge
   always_ff @(posedge clk) begin
      if (rst) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_d <= 1'b0;
      end else begin
         meta   <= req;
         sync   <= meta;
         sync_d <= sync;
      end
   end

   assign rise_c = sync & ~sync_d;

endmodule

// File: rtl/irq_status.sv
// Podule interrupt-status block: per-source edge/level pending latches,
// mask, IRQ/FIQ routing and a priority-encoded vector register.
module irq_status
   import irq_status_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cs,
   input  logic              strobe,
   input  logic              rnw,
   input  logic [ADDR_W-1:0] a,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   input  logic [NUM_SRC-1:0] irq_in,
   output logic              irq_out,
   output logic              fiq_out
);

   logic [NUM_SRC-1:0] sync;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] pend;
   logic [NUM_SRC-1:0] mask;
   logic [DATA_W-1:0]  mode;
   logic [NUM_SRC-1:0] edge_mode;
   logic [NUM_SRC-1:0] route;
   logic [NUM_SRC-1:0] active;
   logic               wr_en;
   logic               rd_en;
   logic [NUM_SRC-1:0] clr_c;
   logic [NUM_SRC-1:0] pend_nxt_c;
   vector_t            vec_c;
   logic [DATA_W-1:0]  rd_mux_c;

   irq_sync_edge u_econet (
      .clk(clk), .rst(rst), .req(irq_in[SRC_ECONET]),
      .sync(sync[SRC_ECONET]), .rise_c(rise[SRC_ECONET]));
   irq_sync_edge u_ethernet (
      .clk(clk), .rst(rst), .req(irq_in[SRC_ETHERNET]),
      .sync(sync[SRC_ETHERNET]), .rise_c(rise[SRC_ETHERNET]));
   irq_sync_edge u_ide (
      .clk(clk), .rst(rst), .req(irq_in[SRC_IDE]),
      .sync(sync[SRC_IDE]), .rise_c(rise[SRC_IDE]));
   irq_sync_edge u_uart (
      .clk(clk), .rst(rst), .req(irq_in[SRC_UART]),
      .sync(sync[SRC_UART]), .rise_c(rise[SRC_UART]));

   assign edge_mode = mode[NUM_SRC-1:0];
   assign route     = mode[DATA_W-1:NUM_SRC];
   assign active    = pend & mask;
   assign wr_en     = cs & strobe & ~rnw;
   assign rd_en     = cs & strobe & rnw;

   // Edge sources: a new edge beats a same-cycle clear. Level sources track sync.
   always_comb begin
      clr_c      = '0;
      pend_nxt_c = '0;
      if (wr_en && (a == REG_STATUS)) clr_c = wdata[NUM_SRC-1:0];
      pend_nxt_c = (edge_mode & (rise | (pend & ~clr_c))) | (~edge_mode & sync);
   end

   // Priority encoder, bit 0 highest priority
   always_comb begin
      vec_c = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (active[i] && !vec_c.valid) begin
            vec_c.valid = 1'b1;
            vec_c.id    = ID_W'(i);
         end
      end
   end

   always_comb begin
      rd_mux_c = '0;
      case (a)
         REG_STATUS: rd_mux_c = DATA_W'(pend);
         REG_MASK:   rd_mux_c = DATA_W'(mask);
         REG_MODE:   rd_mux_c = mode;
         default:    rd_mux_c = pack_vector(vec_c);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend    <= '0;
         mask    <= '0;
         mode    <= '0;
         rdata   <= '0;
         irq_out <= 1'b0;
         fiq_out <= 1'b0;
      end else begin
         pend    <= pend_nxt_c;
         irq_out <= |(active & ~route);
         fiq_out <= |(active & route);
         if (rd_en) rdata <= rd_mux_c;
         if (wr_en) begin
            case (a)
               REG_MASK: mask <= wdata[NUM_SRC-1:0];
               REG_MODE: mode <= wdata;
               default:  ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_irq_status.sv
// Self-checking bench for irq_status: directed scenarios followed by random
// traffic, every cycle compared against a sample-history reference model.
module tb_irq_status;
   import irq_status_pkg::*;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic       cs     = 1'b0;
   logic       strobe = 1'b0;
   logic       rnw    = 1'b1;
   logic [1:0] a      = 2'b00;
   logic [7:0] wdata  = 8'h00;
   logic [3:0] irq_in = 4'h0;
   logic [7:0] rdata;
   logic       irq_out;
   logic       fiq_out;

   always #5 clk = ~clk;

   irq_status dut (
      .clk(clk), .rst(rst), .cs(cs), .strobe(strobe), .rnw(rnw), .a(a),
      .wdata(wdata), .rdata(rdata), .irq_in(irq_in),
      .irq_out(irq_out), .fiq_out(fiq_out)
   );

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   // Reference model: hist[k] is irq_in as sampled k edges ago
   logic [3:0] hist [0:3];
   logic [3:0] m_pend  = 4'h0;
   logic [3:0] m_mask  = 4'h0;
   logic [7:0] m_mode  = 8'h00;
   logic [7:0] m_rdata = 8'h00;
   logic       m_irq   = 1'b0;
   logic       m_fiq   = 1'b0;

   function automatic logic [7:0] m_vector(input logic [3:0] act);
      for (int i = 0; i < 4; i++) if (act[i]) return {1'b1, 4'b0000, 3'(i)};
      return 8'h00;
   endfunction

   function automatic logic [7:0] m_read(input logic [1:0] sel);
      case (sel)
         2'd0:    return {4'h0, m_pend};
         2'd1:    return {4'h0, m_mask};
         2'd2:    return m_mode;
         default: return m_vector(m_pend & m_mask);
      endcase
   endfunction

   task automatic model_edge();
      logic [3:0] lvl, rise, clr, new_pend;
      if (rst) begin
         for (int k = 0; k < 4; k++) hist[k] = 4'h0;
         m_pend = 4'h0; m_mask = 4'h0; m_mode = 8'h00;
         m_rdata = 8'h00; m_irq = 1'b0; m_fiq = 1'b0;
         return;
      end
      for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = irq_in;
      // A level seen by pend at this edge was sampled two edges earlier
      lvl  = hist[2];
      rise = hist[2] & ~hist[3];
      clr  = (cs && strobe && !rnw && a == 2'd0) ? wdata[3:0] : 4'h0;
      for (int n = 0; n < 4; n++)
         new_pend[n] = m_mode[n] ? (rise[n] || (m_pend[n] && !clr[n])) : lvl[n];
      if (cs && strobe && rnw) m_rdata = m_read(a);
      m_irq = |(m_pend & m_mask & ~m_mode[7:4]);
      m_fiq = |(m_pend & m_mask & m_mode[7:4]);
      if (cs && strobe && !rnw) begin
         if (a == 2'd1) m_mask = wdata[3:0];
         if (a == 2'd2) m_mode = wdata;
      end
      m_pend = new_pend;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("rdata",   rdata,            m_rdata);
      check("irq_out", {7'b0, irq_out}, {7'b0, m_irq});
      check("fiq_out", {7'b0, fiq_out}, {7'b0, m_fiq});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [1:0] ra, input logic [7:0] d);
      cs = 1'b1; strobe = 1'b1; rnw = 1'b0; a = ra; wdata = d;
      tick();
      cs = 1'b0; strobe = 1'b0; rnw = 1'b1;
   endtask

   task automatic rd(input logic [1:0] ra);
      cs = 1'b1; strobe = 1'b1; rnw = 1'b1; a = ra;
      tick();
      cs = 1'b0; strobe = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 4; k++) hist[k] = 4'h0;

      // Reset, then every register reads zero
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      for (int r = 0; r < 4; r++) begin
         rd(2'(r));
         check("reset_read", rdata, 8'h00);
      end
      check("reset_irq", {7'b0, irq_out}, 8'h00);
      check("reset_fiq", {7'b0, fiq_out}, 8'h00);

      // One-clock pulse on IDE in edge mode: pend three clocks later, IRQ one after
      wr(REG_MODE, 8'h0F);
      wr(REG_MASK, 8'h04);
      irq_in = 4'h4;
      tick();
      irq_in = 4'h0;
      tick();
      rd(REG_STATUS);
      check("ide_status_early", rdata, 8'h00);
      rd(REG_STATUS);
      check("ide_status", rdata, 8'h04);
      check("ide_irq_set", {7'b0, irq_out}, 8'h01);
      rd(REG_VECTOR);
      check("ide_vector", rdata, 8'h82);
      wr(REG_STATUS, 8'h04);
      check("ide_irq_clear_edge", {7'b0, irq_out}, 8'h01);
      tick();
      check("ide_irq_cleared", {7'b0, irq_out}, 8'h00);

      // Econet routed to FIQ, UART to IRQ; Econet wins the vector
      wr(REG_MODE, 8'h1F);
      wr(REG_MASK, 8'h0F);
      irq_in = 4'h9;
      idle(4);
      check("route_fiq", {7'b0, fiq_out}, 8'h01);
      check("route_irq", {7'b0, irq_out}, 8'h01);
      rd(REG_VECTOR);
      check("route_vector", rdata, 8'h80);
      irq_in = 4'h0;
      wr(REG_STATUS, 8'h0F);
      idle(3);

      // Clear in the same clock as the set: set wins
      irq_in = 4'h2;
      idle(2);
      wr(REG_STATUS, 8'h02);
      rd(REG_STATUS);
      check("set_beats_clear", rdata, 8'h02);
      wr(REG_STATUS, 8'h02);
      rd(REG_STATUS);
      check("edge_cleared", rdata, 8'h00);
      irq_in = 4'h0;
      idle(3);

      // Level mode follows the input and ignores clears
      wr(REG_MODE, 8'h00);
      wr(REG_MASK, 8'h08);
      irq_in = 4'h8;
      idle(4);
      rd(REG_STATUS);
      check("level_status", rdata, 8'h08);
      wr(REG_STATUS, 8'h08);
      rd(REG_STATUS);
      check("level_no_clear", rdata, 8'h08);
      irq_in = 4'h0;
      idle(3);
      check("level_drop_3", {7'b0, irq_out}, 8'h01);
      tick();
      check("level_drop_4", {7'b0, irq_out}, 8'h00);

      // Reset with all sources pending and Ethernet held high
      wr(REG_MODE, 8'h0F);
      irq_in = 4'hF;
      idle(4);
      rd(REG_STATUS);
      check("pre_reset_pend", rdata, 8'h0F);
      irq_in = 4'h2;
      rst = 1'b1;
      tick();
      cs = 1'b1; strobe = 1'b1; rnw = 1'b0; a = REG_MASK; wdata = 8'hFF;
      tick();
      cs = 1'b0; strobe = 1'b0; rnw = 1'b1;
      rst = 1'b0;
      rd(REG_MASK);
      check("reset_abort_write", rdata, 8'h00);
      wr(REG_MODE, 8'h0F);
      idle(1);
      rd(REG_STATUS);
      check("post_reset_edge", rdata, 8'h02);
      // Strobes without chip select change nothing
      cs = 1'b0; strobe = 1'b1;
      rnw = 1'b0; a = REG_MASK;   wdata = 8'hFF; tick();
      rnw = 1'b0; a = REG_STATUS; wdata = 8'hFF; tick();
      rnw = 1'b0; a = REG_MODE;   wdata = 8'h00; tick();
      rnw = 1'b1; a = REG_MASK;                  tick();
      check("nocs_rdata_hold", rdata, 8'h02);
      strobe = 1'b0;
      rd(REG_STATUS);
      check("nocs_status", rdata, 8'h02);
      rd(REG_MASK);
      check("nocs_mask", rdata, 8'h00);
      rd(REG_MODE);
      check("nocs_mode", rdata, 8'h0F);

      // Random traffic against the model
      for (int i = 0; i < 800; i++) begin
         rst    = ($urandom_range(0, 63) == 0);
         cs     = ($urandom_range(0, 3) != 0);
         strobe = ($urandom_range(0, 1) == 1);
         rnw    = ($urandom_range(0, 1) == 1);
         a      = 2'($urandom);
         wdata  = 8'($urandom);
         if ($urandom_range(0, 5) == 0) irq_in = 4'($urandom);
         tick();
      end
      rst = 1'b0; cs = 1'b0; strobe = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
